// File: rtl/duck_flight_ctrl.sv
// Single-duck flight sequencer: spawn, tick-gated flap/fly with edge bounce,
// hit pause and fall, or fly-away on timeout. Drives sprite position and frame.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for start; position and frame hold last values
// SPAWN     | one cycle: place duck at clamped start_x on the ground line
// FLY       | per tick: flap, move, bounce; hit or timeout ends it
// HIT_PAUSE | frozen for HIT_TICKS ticks after a hit
// FALL      | per tick: drop by FALL_STEP until the ground line
// FLYAWAY   | per tick: rise by STEP until the top, X held
// DONE      | one cycle done pulse, then IDLE
module duck_flight_ctrl #(
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 608,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 300,
    parameter int STEP      = 4,
    parameter int FALL_STEP = 8,
    parameter int FLY_TICKS = 120,
    parameter int HIT_TICKS = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       anim_tick,
    input  logic       start,
    input  logic [1:0] color_in,
    input  logic [1:0] dir_in,
    input  logic [9:0] start_x,
    input  logic       hit,
    output logic [9:0] Duck_X,
    output logic [9:0] Duck_Y,
    output logic [5:0] DuckFrame,
    output logic       busy,
    output logic       done,
    output logic       shot,
    output logic       escaped
);

    typedef enum logic [2:0] {
        S_IDLE, S_SPAWN, S_FLY, S_HIT_PAUSE, S_FALL, S_FLYAWAY, S_DONE
    } state_t;

    localparam logic [1:0] V_UP    = 2'd0;
    localparam logic [1:0] V_LEVEL = 2'd1;
    localparam logic [1:0] V_DOWN  = 2'd2;

    localparam logic signed [10:0] X_MIN_S  = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S  = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S  = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S  = 11'(Y_MAX);
    localparam logic signed [10:0] STEP_S   = 11'(STEP);
    localparam logic signed [10:0] FALL_S   = 11'(FALL_STEP);
    localparam logic [9:0]         X_MIN_V  = 10'(X_MIN);
    localparam logic [9:0]         X_MAX_V  = 10'(X_MAX);
    localparam logic [9:0]         Y_MIN_V  = 10'(Y_MIN);
    localparam logic [9:0]         Y_MAX_V  = 10'(Y_MAX);

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [5:0]  frame_q, frame_d;
    logic [1:0]  color_q, color_d, dir_q, dir_d;
    logic        hdir_q, hdir_d;          // 1 = moving right
    logic [1:0]  vdir_q, vdir_d;
    logic [1:0]  flap_q, flap_d;
    logic [7:0]  fly_cnt_q, fly_cnt_d;
    logic [7:0]  hit_cnt_q, hit_cnt_d;
    logic        fall_alt_q, fall_alt_d;
    logic        shot_q, shot_d, escaped_q, escaped_d;

    logic signed [10:0] xs, ys, nx, ny, fall_y, away_y, spawn_x;
    logic [9:0]  bx, by;
    logic        bhdir;
    logic [1:0]  bvdir, flap_nxt;

    function automatic logic [5:0] color_base(input logic [1:0] col);
        case (col)
            2'b01:   return 6'd20;
            2'b10:   return 6'd40;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [5:0] fly_frame(input logic [1:0] col, input logic right,
                                             input logic [1:0] vd, input logic [1:0] fl);
        logic [5:0] off;
        if (right) off = (vd == V_UP) ? 6'd0  : 6'd4;
        else       off = (vd == V_UP) ? 6'd11 : 6'd15;
        return color_base(col) + off + {4'b0, fl};
    endfunction

    // Candidate motion in 11-bit signed space so edge overshoot is visible.
    always_comb begin
        xs       = $signed({1'b0, x_q});
        ys       = $signed({1'b0, y_q});
        spawn_x  = $signed({1'b0, start_x});
        nx       = hdir_q ? xs + STEP_S : xs - STEP_S;
        case (vdir_q)
            V_UP:    ny = ys - STEP_S;
            V_DOWN:  ny = ys + STEP_S;
            default: ny = ys;
        endcase
        fall_y   = ys + FALL_S;
        away_y   = ys - STEP_S;
        flap_nxt = (flap_q == 2'd2) ? 2'd0 : flap_q + 2'd1;

        bx    = nx[9:0];
        bhdir = hdir_q;
        if (nx < X_MIN_S) begin
            bx    = X_MIN_V;
            bhdir = 1'b1;
        end else if (nx > X_MAX_S) begin
            bx    = X_MAX_V;
            bhdir = 1'b0;
        end
        by    = ny[9:0];
        bvdir = vdir_q;
        if (ny < Y_MIN_S) begin
            by    = Y_MIN_V;
            bvdir = V_DOWN;
        end else if (ny > Y_MAX_S) begin
            by    = Y_MAX_V;
            bvdir = V_UP;
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        frame_d    = frame_q;
        color_d    = color_q;
        dir_d      = dir_q;
        hdir_d     = hdir_q;
        vdir_d     = vdir_q;
        flap_d     = flap_q;
        fly_cnt_d  = fly_cnt_q;
        hit_cnt_d  = hit_cnt_q;
        fall_alt_d = fall_alt_q;
        shot_d     = shot_q;
        escaped_d  = escaped_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SPAWN;
                    color_d   = color_in;
                    dir_d     = dir_in;
                    shot_d    = 1'b0;
                    escaped_d = 1'b0;
                end
            end
            S_SPAWN: begin
                if (spawn_x > X_MAX_S)      x_d = X_MAX_V;
                else if (spawn_x < X_MIN_S) x_d = X_MIN_V;
                else                        x_d = start_x;
                y_d       = Y_MAX_V;
                hdir_d    = dir_q[1];
                vdir_d    = dir_q[0] ? V_LEVEL : V_UP;
                fly_cnt_d = 8'd0;
                flap_d    = 2'd0;
                state_d   = S_FLY;
            end
            S_FLY: begin
                // A hit outranks a coincident timeout tick and suppresses the move.
                if (hit) begin
                    state_d   = S_HIT_PAUSE;
                    hit_cnt_d = 8'(HIT_TICKS);
                    frame_d   = color_base(color_q) + 6'd8;
                end else if (anim_tick) begin
                    flap_d    = flap_nxt;
                    fly_cnt_d = fly_cnt_q + 8'd1;
                    x_d       = bx;
                    y_d       = by;
                    hdir_d    = bhdir;
                    vdir_d    = bvdir;
                    frame_d   = fly_frame(color_q, bhdir, bvdir, flap_nxt);
                    if (fly_cnt_q + 8'd1 == 8'(FLY_TICKS)) state_d = S_FLYAWAY;
                end
            end
            S_HIT_PAUSE: begin
                if (anim_tick) begin
                    hit_cnt_d = hit_cnt_q - 8'd1;
                    if (hit_cnt_q == 8'd1) begin
                        state_d    = S_FALL;
                        fall_alt_d = 1'b0;
                    end
                end
            end
            S_FALL: begin
                if (anim_tick) begin
                    frame_d    = color_base(color_q) + 6'd9 + {5'b0, fall_alt_q};
                    fall_alt_d = ~fall_alt_q;
                    if (fall_y >= Y_MAX_S) begin
                        y_d     = Y_MAX_V;
                        shot_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        y_d = fall_y[9:0];
                    end
                end
            end
            S_FLYAWAY: begin
                if (anim_tick) begin
                    flap_d  = flap_nxt;
                    frame_d = fly_frame(color_q, hdir_q, V_UP, flap_nxt);
                    if (away_y <= Y_MIN_S) begin
                        y_d       = Y_MIN_V;
                        escaped_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        y_d = away_y[9:0];
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            frame_q    <= '0;
            color_q    <= '0;
            dir_q      <= '0;
            hdir_q     <= 1'b0;
            vdir_q     <= V_UP;
            flap_q     <= '0;
            fly_cnt_q  <= '0;
            hit_cnt_q  <= '0;
            fall_alt_q <= 1'b0;
            shot_q     <= 1'b0;
            escaped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            frame_q    <= frame_d;
            color_q    <= color_d;
            dir_q      <= dir_d;
            hdir_q     <= hdir_d;
            vdir_q     <= vdir_d;
            flap_q     <= flap_d;
            fly_cnt_q  <= fly_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            fall_alt_q <= fall_alt_d;
            shot_q     <= shot_d;
            escaped_q  <= escaped_d;
        end
    end

    assign Duck_X    = x_q;
    assign Duck_Y    = y_q;
    assign DuckFrame = frame_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign shot      = shot_q;
    assign escaped   = escaped_q;

endmodule

// File: tb/tb_duck_flight_ctrl.sv
// Directed bench for duck_flight_ctrl: spawn/first-tick vector table plus
// hand-written timeout, hit, coincident hit/timeout and async reset sequences.
module tb_duck_flight_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, anim_tick, start, hit;
    logic [1:0] color_in, dir_in;
    logic [9:0] start_x;
    logic [9:0] Duck_X, Duck_Y;
    logic [5:0] DuckFrame;
    logic       busy, done, shot, escaped;

    int errors = 0;
    int checks = 0;

    duck_flight_ctrl dut (
        .Clk(Clk), .Reset(Reset), .anim_tick(anim_tick), .start(start),
        .color_in(color_in), .dir_in(dir_in), .start_x(start_x), .hit(hit),
        .Duck_X(Duck_X), .Duck_Y(Duck_Y), .DuckFrame(DuckFrame),
        .busy(busy), .done(done), .shot(shot), .escaped(escaped)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] c;
        logic [1:0] d;
        logic [9:0] sx;
        int         x0;
        int         x1;
        int         y1;
        int         f1;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick(input logic h);
        anim_tick = 1'b1;
        hit       = h;
        cyc();
        anim_tick = 1'b0;
        hit       = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        cyc();
        cyc();
        Reset = 1'b1;
        cyc();
    endtask

    // anim_tick is held high through IDLE and SPAWN; it must not disturb the spawn.
    task automatic launch(input logic [1:0] c, input logic [1:0] d, input logic [9:0] sx);
        color_in  = c;
        dir_in    = d;
        start_x   = sx;
        start     = 1'b1;
        anim_tick = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        anim_tick = 1'b0;
    endtask

    task automatic run_to_done(input int bound, output int n);
        n = 0;
        for (int i = 0; i < bound; i++) begin
            tick(1'b0);
            n++;
            if (done) break;
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{2'b01, 2'b10, 10'd100,  100, 104, 296, 21};
        tbl[1] = '{2'b00, 2'b00, 10'd200,  200, 196, 296, 12};
        tbl[2] = '{2'b10, 2'b01, 10'd50,   50,  46,  300, 56};
        tbl[3] = '{2'b11, 2'b11, 10'd1000, 608, 608, 300, 16};
        tbl[4] = '{2'b00, 2'b11, 10'd600,  600, 604, 300, 5};
        tbl[5] = '{2'b01, 2'b01, 10'd0,    0,   0,   300, 25};
        tbl[6] = '{2'b00, 2'b00, 10'd2,    2,   0,   296, 1};
        tbl[7] = '{2'b10, 2'b10, 10'd606,  606, 608, 296, 52};

        Reset = 1'b0; anim_tick = 1'b0; start = 1'b0; hit = 1'b0;
        color_in = '0; dir_in = '0; start_x = '0;
        cyc();
        check("rst_x", Duck_X, 0);
        check("rst_y", Duck_Y, 0);
        check("rst_frame", DuckFrame, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {done, shot, escaped}, 0);
        Reset = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) begin
            do_reset();
            launch(tbl[i].c, tbl[i].d, tbl[i].sx);
            check($sformatf("v%0d_spawn_x", i), Duck_X, tbl[i].x0);
            check($sformatf("v%0d_spawn_y", i), Duck_Y, 300);
            check($sformatf("v%0d_busy", i), busy, 1);
            tick(1'b0);
            check($sformatf("v%0d_x1", i), Duck_X, tbl[i].x1);
            check($sformatf("v%0d_y1", i), Duck_Y, tbl[i].y1);
            check($sformatf("v%0d_f1", i), DuckFrame, tbl[i].f1);
        end

        // Right-edge bounce while flying level
        do_reset();
        launch(2'b00, 2'b11, 10'd600);
        tick(1'b0); check("edge_t1_x", Duck_X, 604);
        tick(1'b0); check("edge_t2_x", Duck_X, 608); check("edge_t2_y", Duck_Y, 300);
        tick(1'b0); check("edge_t3_x", Duck_X, 608); check("edge_t3_f", DuckFrame, 15);
        tick(1'b0); check("edge_t4_x", Duck_X, 604);

        // Timeout path: W level from 300 bounces off X=0 at tick 76
        do_reset();
        launch(2'b00, 2'b01, 10'd300);
        for (int i = 1; i <= 120; i++) begin
            tick(1'b0);
            if (i == 76) check("to_bounce_x", Duck_X, 0);
        end
        check("to_x120", Duck_X, 176);
        check("to_y120", Duck_Y, 300);
        check("to_f120", DuckFrame, 4);
        tick(1'b0);
        check("fa_y1", Duck_Y, 296);
        check("fa_x1", Duck_X, 176);
        check("fa_f1", DuckFrame, 1);
        run_to_done(100, n);
        check("fa_ticks", n, 74);
        check("fa_done", done, 1);
        check("fa_y_end", Duck_Y, 0);
        check("fa_escaped", escaped, 1);
        check("fa_shot", shot, 0);
        cyc();
        check("fa_done_pulse", done, 0);
        check("fa_idle_busy", busy, 0);
        check("fa_hold_x", Duck_X, 176);
        check("fa_hold_esc", escaped, 1);

        // Hit on 5th FLY tick, pink, without reset: start clears escaped
        launch(2'b10, 2'b10, 10'd100);
        check("hit_esc_clr", escaped, 0);
        for (int i = 0; i < 4; i++) tick(1'b0);
        check("hit_pre_x", Duck_X, 116);
        check("hit_pre_y", Duck_Y, 284);
        tick(1'b1);
        check("hit_frz_x", Duck_X, 116);
        check("hit_frz_y", Duck_Y, 284);
        check("hit_frame", DuckFrame, 48);
        for (int i = 0; i < 10; i++) tick(1'b0);
        check("hit_pause_y", Duck_Y, 284);
        check("hit_pause_f", DuckFrame, 48);
        tick(1'b0);
        check("fall1_y", Duck_Y, 292);
        check("fall1_f", DuckFrame, 49);
        tick(1'b0);
        check("fall2_y", Duck_Y, 300);
        check("fall2_f", DuckFrame, 50);
        check("fall_done", done, 1);
        check("fall_shot", shot, 1);
        check("fall_esc", escaped, 0);
        cyc();

        // Hit coincident with the 120th tick; start while busy is ignored
        launch(2'b00, 2'b01, 10'd300);
        check("co_shot_clr", shot, 0);
        for (int i = 0; i < 119; i++) tick(1'b0);
        check("co_x119", Duck_X, 172);
        tick(1'b1);
        check("co_frz_x", Duck_X, 172);
        check("co_frame", DuckFrame, 8);
        color_in = 2'b01; dir_in = 2'b10; start_x = 10'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        check("co_busy_x", Duck_X, 172);
        check("co_busy_f", DuckFrame, 8);
        check("co_busy", busy, 1);
        for (int i = 0; i < 10; i++) tick(1'b0);
        check("co_pause_x", Duck_X, 172);
        tick(1'b0);
        check("co_done", done, 1);
        check("co_y", Duck_Y, 300);
        check("co_fall_f", DuckFrame, 9);
        check("co_shot", shot, 1);
        check("co_esc", escaped, 0);
        cyc();

        // Async reset mid-FALL; hit taken on a non-tick cycle
        launch(2'b10, 2'b10, 10'd100);
        for (int i = 0; i < 4; i++) tick(1'b0);
        hit = 1'b1;
        cyc();
        hit = 1'b0;
        check("nt_hit_f", DuckFrame, 48);
        for (int i = 0; i < 10; i++) tick(1'b0);
        tick(1'b0);
        check("mid_fall_y", Duck_Y, 292);
        Reset = 1'b0;
        #2;
        check("ar_x", Duck_X, 0);
        check("ar_y", Duck_Y, 0);
        check("ar_frame", DuckFrame, 0);
        check("ar_busy", busy, 0);
        check("ar_flags", {done, shot, escaped}, 0);
        cyc();
        Reset = 1'b1;
        cyc();
        launch(2'b01, 2'b00, 10'd700);
        check("ar_spawn_x", Duck_X, 608);
        check("ar_spawn_y", Duck_Y, 300);
        check("ar_spawn_busy", busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
